sw_wavefront_ctrl: RTL and testbench

Sequencing controller for the Smith-Waterman scoring datapath. It drives a linear array of NUM_PE processing elements in anti-diagonal wavefront order over a REF_LEN x QUERY_LEN score matrix, processing the query in strips of NUM_PE rows. It issues query-load, reference-feed, per-PE enable and inter-strip boundary-buffer read/write strobes, and reports completion to the top-level FSM that collects max/pos_ref/pos_query.

---
 rtl/sw_wavefront_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_sw_wavefront_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_wavefront_ctrl.sv
// sw_wavefront_ctrl: sequencing controller for a Smith-Waterman linear PE array.
// Walks a REF_LEN x QUERY_LEN score matrix in strips of NUM_PE query rows.
// For each strip it first loads NUM_PE query symbols into the PE chain.
// It then streams the reference through the chain in anti-diagonal order,
// one wave step per cycle.
//
// Ports:
//   clk, reset (async, active-high)
//   start            begin an alignment (sampled only in IDLE)
//   stall            freeze sequencing; strobes forced low this cycle
//   busy, done       run in progress / one-cycle completion pulse
//   strip            current strip index
//   q_load, q_addr   query symbol load into the PE chain
//   ref_valid, ref_addr        reference symbol entering PE0
//   pe_active        per-PE valid-cell enable
//   bnd_wr, bnd_wr_addr        last-PE result to boundary buffer
//   bnd_rd, bnd_rd_addr        boundary row read for PE0
//   perf_cycles      busy-cycle counter (only with SW_CTRL_PERF_EN defined)
//
// Optional feature macro: SW_CTRL_PERF_EN adds the perf_cycles output.
module sw_wavefront_ctrl #(
   parameter int unsigned REF_LEN   = 64,
   parameter int unsigned QUERY_LEN = 48,
   parameter int unsigned NUM_PE    = 16,
   localparam int unsigned STRIPS   = QUERY_LEN / NUM_PE,
   localparam int unsigned SW       = (STRIPS > 1) ? $clog2(STRIPS) : 1,
   localparam int unsigned QW       = (QUERY_LEN > 1) ? $clog2(QUERY_LEN) : 1,
   localparam int unsigned RW       = (REF_LEN > 1) ? $clog2(REF_LEN) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stall,
   output logic              busy,
   output logic              done,
   output logic [SW-1:0]     strip,
   output logic              q_load,
   output logic [QW-1:0]     q_addr,
   output logic              ref_valid,
   output logic [RW-1:0]     ref_addr,
   output logic [NUM_PE-1:0] pe_active,
   output logic              bnd_wr,
   output logic [RW-1:0]     bnd_wr_addr,
   output logic              bnd_rd,
   output logic [RW-1:0]     bnd_rd_addr
`ifdef SW_CTRL_PERF_EN
   ,
   output logic [15:0]       perf_cycles
`endif
);

   localparam int unsigned LW     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam int unsigned T_LAST = REF_LEN + NUM_PE - 2;
   localparam int unsigned TW     = (T_LAST > 0) ? $clog2(T_LAST + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAVE, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [SW-1:0]   strip_q, strip_d;
   logic [LW-1:0]   lc_q, lc_d;
   logic [TW-1:0]   t_q, t_d;
   logic [NUM_PE-1:0] pe_raw;
   logic            ref_in;
   logic            last_strip;

   // State and counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         strip_q <= '0;
         lc_q    <= '0;
         t_q     <= '0;
      end else begin
         state_q <= state_d;
         strip_q <= strip_d;
         lc_q    <= lc_d;
         t_q     <= t_d;
      end
   end

   assign last_strip = (strip_q == SW'(STRIPS - 1));

   // Next-state and counter sequencing; stall freezes everything except IDLE/DONE
   always_comb begin
      state_d = state_q;
      strip_d = strip_q;
      lc_d    = lc_q;
      t_d     = t_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               strip_d = '0;
               lc_d    = '0;
            end
         end
         S_LOAD: begin
            if (!stall) begin
               if (32'(lc_q) == NUM_PE - 1) begin
                  state_d = S_WAVE;
                  t_d     = '0;
               end else begin
                  lc_d = lc_q + LW'(1);
               end
            end
         end
         S_WAVE: begin
            if (!stall) begin
               if (32'(t_q) == T_LAST) begin
                  if (last_strip) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_LOAD;
                     strip_d = strip_q + SW'(1);
                     lc_d    = '0;
                  end
               end else begin
                  t_d = t_q + TW'(1);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // PE k holds a valid cell when reference symbol t-k is inside the matrix
   for (genvar k = 0; k < int'(NUM_PE); k++) begin : g_pe
      assign pe_raw[k] = (32'(t_q) >= 32'(k)) && ((32'(t_q) - 32'(k)) < REF_LEN);
   end

   assign ref_in = (32'(t_q) < REF_LEN);

   // Output decode of registered state; strobes gated by stall, addresses not
   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      strip       = strip_q;
      q_load      = 1'b0;
      q_addr      = '0;
      ref_valid   = 1'b0;
      ref_addr    = '0;
      pe_active   = '0;
      bnd_wr      = 1'b0;
      bnd_wr_addr = '0;
      bnd_rd      = 1'b0;
      bnd_rd_addr = '0;
      case (state_q)
         S_LOAD: begin
            busy   = 1'b1;
            q_load = !stall;
            q_addr = QW'(32'(strip_q) * NUM_PE + 32'(lc_q));
         end
         S_WAVE: begin
            busy      = 1'b1;
            ref_valid = ref_in && !stall;
            ref_addr  = ref_in ? RW'(t_q) : '0;
            pe_active = stall ? '0 : pe_raw;
            if ((32'(t_q) >= NUM_PE - 1) && !last_strip) begin
               bnd_wr      = !stall;
               bnd_wr_addr = RW'(32'(t_q) - (NUM_PE - 1));
            end
            if (ref_in && (strip_q != '0)) begin
               bnd_rd      = !stall;
               bnd_rd_addr = RW'(t_q);
            end
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

`ifdef SW_CTRL_PERF_EN
   logic [15:0] perf_q, perf_d;

   // Busy-cycle counter: cleared on accepted start, saturating, holds after done
   always_comb begin
      perf_d = perf_q;
      if ((state_q == S_IDLE) && start) begin
         perf_d = '0;
      end else if (busy && (perf_q != 16'hFFFF)) begin
         perf_d = perf_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) perf_q <= '0;
      else       perf_q <= perf_d;
   end

   assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_sw_wavefront_ctrl.sv
// Testbench for sw_wavefront_ctrl: scoreboard of expected strobe/address
// streams plus per-scenario timing checks. A second instance exercises the
// single-strip configuration (NUM_PE = QUERY_LEN = 48).
module tb_sw_wavefront_ctrl;

   localparam int REF_LEN   = 64;
   localparam int QUERY_LEN = 48;
   localparam int NUM_PE    = 16;
   localparam int STRIPS    = QUERY_LEN / NUM_PE;
   localparam int TOTAL     = STRIPS * (REF_LEN + 2 * NUM_PE - 1);

   logic clk = 1'b0;
   logic reset, start, stall, start48, stall48;

   logic              busy, done, q_load, ref_valid, bnd_wr, bnd_rd;
   logic [1:0]        strip;
   logic [5:0]        q_addr, ref_addr, bnd_wr_addr, bnd_rd_addr;
   logic [NUM_PE-1:0] pe_active;

   logic              busy48, done48, q_load48, ref_valid48, bnd_wr48, bnd_rd48;
   logic [0:0]        strip48;
   logic [5:0]        q_addr48, ref_addr48, bnd_wr_addr48, bnd_rd_addr48;
   logic [47:0]       pe_active48;
`ifdef SW_CTRL_PERF_EN
   logic [15:0]       perf_cycles, perf_cycles48;
`endif

   sw_wavefront_ctrl #(.REF_LEN(REF_LEN), .QUERY_LEN(QUERY_LEN), .NUM_PE(NUM_PE)) dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall),
      .busy(busy), .done(done), .strip(strip),
      .q_load(q_load), .q_addr(q_addr),
      .ref_valid(ref_valid), .ref_addr(ref_addr),
      .pe_active(pe_active),
      .bnd_wr(bnd_wr), .bnd_wr_addr(bnd_wr_addr),
      .bnd_rd(bnd_rd), .bnd_rd_addr(bnd_rd_addr)
`ifdef SW_CTRL_PERF_EN
      , .perf_cycles(perf_cycles)
`endif
   );

   sw_wavefront_ctrl #(.REF_LEN(64), .QUERY_LEN(48), .NUM_PE(48)) dut48 (
      .clk(clk), .reset(reset), .start(start48), .stall(stall48),
      .busy(busy48), .done(done48), .strip(strip48),
      .q_load(q_load48), .q_addr(q_addr48),
      .ref_valid(ref_valid48), .ref_addr(ref_addr48),
      .pe_active(pe_active48),
      .bnd_wr(bnd_wr48), .bnd_wr_addr(bnd_wr_addr48),
      .bnd_rd(bnd_rd48), .bnd_rd_addr(bnd_rd_addr48)
`ifdef SW_CTRL_PERF_EN
      , .perf_cycles(perf_cycles48)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   int                q_exp[$];
   int                r_exp[$];
   int                w_exp[$];
   int                rd_exp[$];
   logic [NUM_PE-1:0] pe_exp[$];

   int                m_e;
   logic [NUM_PE-1:0] m_pe;

   // Scoreboard consumer: every strobe pops and compares its expected address
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (q_load === 1'b1) begin
            n_checks++;
            if (q_exp.size() == 0) $display("FAIL sb_q_load unexpected: q_addr=%0d", q_addr);
            else begin
               m_e = q_exp.pop_front();
               if (32'(q_addr) !== m_e) $display("FAIL sb_q_addr got=%0d exp=%0d", q_addr, m_e);
               else n_pass++;
            end
         end
         if (ref_valid === 1'b1) begin
            n_checks++;
            if (r_exp.size() == 0) $display("FAIL sb_ref unexpected: ref_addr=%0d", ref_addr);
            else begin
               m_e = r_exp.pop_front();
               if (32'(ref_addr) !== m_e) $display("FAIL sb_ref_addr got=%0d exp=%0d", ref_addr, m_e);
               else n_pass++;
            end
         end
         if (pe_active !== '0) begin
            n_checks++;
            if (pe_exp.size() == 0) $display("FAIL sb_pe unexpected: pe_active=%h", pe_active);
            else begin
               m_pe = pe_exp.pop_front();
               if (pe_active !== m_pe) $display("FAIL sb_pe_active got=%h exp=%h", pe_active, m_pe);
               else n_pass++;
            end
         end
         if (bnd_wr === 1'b1) begin
            n_checks++;
            if (w_exp.size() == 0) $display("FAIL sb_bnd_wr unexpected: addr=%0d strip=%0d", bnd_wr_addr, strip);
            else begin
               m_e = w_exp.pop_front();
               if (32'(bnd_wr_addr) !== m_e) $display("FAIL sb_bnd_wr_addr got=%0d exp=%0d", bnd_wr_addr, m_e);
               else n_pass++;
            end
         end
         if (bnd_rd === 1'b1) begin
            n_checks++;
            if (rd_exp.size() == 0) $display("FAIL sb_bnd_rd unexpected: addr=%0d strip=%0d", bnd_rd_addr, strip);
            else begin
               m_e = rd_exp.pop_front();
               if (32'(bnd_rd_addr) !== m_e) $display("FAIL sb_bnd_rd_addr got=%0d exp=%0d", bnd_rd_addr, m_e);
               else n_pass++;
            end
         end
      end
   end

   // Expected strobe streams for one complete alignment
   task automatic push_run();
      for (int s = 0; s < STRIPS; s++) begin
         for (int l = 0; l < NUM_PE; l++) q_exp.push_back(s * NUM_PE + l);
         for (int t = 0; t <= REF_LEN + NUM_PE - 2; t++) begin
            logic [NUM_PE-1:0] p;
            p = '0;
            for (int k = 0; k < NUM_PE; k++)
               if (t >= k && t - k < REF_LEN) p = p | (NUM_PE'(1) << k);
            pe_exp.push_back(p);
            if (t < REF_LEN) begin
               r_exp.push_back(t);
               if (s > 0) rd_exp.push_back(t);
            end
            if (t >= NUM_PE - 1 && s < STRIPS - 1) w_exp.push_back(t - (NUM_PE - 1));
         end
      end
   endtask

   task automatic flush_sb();
      q_exp.delete(); r_exp.delete(); w_exp.delete(); rd_exp.delete(); pe_exp.delete();
   endtask

   // Pulse start for one edge; returns the edge count N of the accepting edge
   task automatic start_run(output int n0);
      push_run();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n0 = cyc;
   endtask

   // Waits for done; lat is the cycle number relative to N (done expected at N+286)
   task automatic wait_done(input int n0, input int limit, output int lat, output int nbusy, output bit seen);
      nbusy = 0; seen = 1'b0; lat = -1;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         if (busy === 1'b1) nbusy++;
         if (done === 1'b1) begin seen = 1'b1; lat = cyc + 1 - n0; end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; stall = 1'b0; start48 = 1'b0; stall48 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({busy, done, q_load, ref_valid, bnd_wr, bnd_rd} !== 6'b0)
         $display("FAIL reset_strobes got=%b exp=000000", {busy, done, q_load, ref_valid, bnd_wr, bnd_rd});
      else n_pass++;
      n_checks++;
      if ({strip, q_addr, ref_addr, bnd_wr_addr, bnd_rd_addr} !== 26'b0)
         $display("FAIL reset_addrs got=%h exp=0", {strip, q_addr, ref_addr, bnd_wr_addr, bnd_rd_addr});
      else n_pass++;
      n_checks++;
      if (pe_active !== '0) $display("FAIL reset_pe_active got=%h exp=0", pe_active);
      else n_pass++;
`ifdef SW_CTRL_PERF_EN
      n_checks++;
      if (perf_cycles !== 16'd0) $display("FAIL reset_perf got=%0d exp=0", perf_cycles);
      else n_pass++;
`endif
      @(posedge clk); #1 reset = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_basic();
      int n0, nbusy, rel;
      bit seen;
      start_run(n0);
      nbusy = 0; seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         rel = cyc - n0;
         if (busy === 1'b1) nbusy++;
         if (rel == 0) begin
            n_checks++;
            if ({busy, q_load, q_addr} !== {1'b1, 1'b1, 6'd0})
               $display("FAIL first_load got busy=%b q_load=%b q_addr=%0d exp 1 1 0", busy, q_load, q_addr);
            else n_pass++;
         end
         if (rel == 16) begin
            n_checks++;
            if (pe_active !== 16'h0001 || ref_valid !== 1'b1 || bnd_wr !== 1'b0)
               $display("FAIL wave_t0 got pe=%h rv=%b wr=%b exp 0001 1 0", pe_active, ref_valid, bnd_wr);
            else n_pass++;
         end
         if (rel == 31) begin
            n_checks++;
            if (pe_active !== 16'hFFFF || bnd_wr !== 1'b1 || bnd_wr_addr !== 6'd0)
               $display("FAIL wave_t15 got pe=%h wr=%b addr=%0d exp FFFF 1 0", pe_active, bnd_wr, bnd_wr_addr);
            else n_pass++;
         end
         if (rel == 94) begin
            n_checks++;
            if (pe_active !== 16'h8000 || bnd_wr !== 1'b1 || bnd_wr_addr !== 6'd63 ||
                ref_valid !== 1'b0 || bnd_rd !== 1'b0)
               $display("FAIL wave_t78 got pe=%h wr=%b addr=%0d rv=%b rd=%b exp 8000 1 63 0 0",
                        pe_active, bnd_wr, bnd_wr_addr, ref_valid, bnd_rd);
            else n_pass++;
         end
         if (rel == 95) begin
            n_checks++;
            if (strip !== 2'd1 || q_addr !== 6'd16)
               $display("FAIL strip1_load got strip=%0d q_addr=%0d exp 1 16", strip, q_addr);
            else n_pass++;
         end
         if (done === 1'b1) begin
            seen = 1'b1;
            n_checks++;
            if (rel + 1 !== TOTAL + 1) $display("FAIL done_latency got=%0d exp=%0d", rel + 1, TOTAL + 1);
            else n_pass++;
         end
      end
      n_checks++;
      if (!seen) $display("FAIL done_timeout got=no_done exp=done");
      else n_pass++;
      n_checks++;
      if (nbusy !== TOTAL) $display("FAIL busy_cycles got=%0d exp=%0d", nbusy, TOTAL);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({done, busy} !== 2'b00) $display("FAIL done_pulse_width got done=%b busy=%b exp 0 0", done, busy);
      else n_pass++;
`ifdef SW_CTRL_PERF_EN
      n_checks++;
      if (perf_cycles !== 16'(TOTAL)) $display("FAIL perf_basic got=%0d exp=%0d", perf_cycles, TOTAL);
      else n_pass++;
`endif
      n_checks++;
      if (q_exp.size() + r_exp.size() + w_exp.size() + rd_exp.size() + pe_exp.size() != 0)
         $display("FAIL sb_leftover_basic got=%0d exp=0",
                  q_exp.size() + r_exp.size() + w_exp.size() + rd_exp.size() + pe_exp.size());
      else n_pass++;
   endtask

   task automatic test_stall();
      int n0, lat, nbusy;
      bit seen;
      start_run(n0);
      repeat (151) @(posedge clk);
      #1 stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if ({q_load, ref_valid, bnd_wr, bnd_rd} !== 4'b0 || pe_active !== '0)
            $display("FAIL stall_strobes got=%b pe=%h exp 0000 0", {q_load, ref_valid, bnd_wr, bnd_rd}, pe_active);
         else n_pass++;
         n_checks++;
         if (ref_addr !== 6'd40 || strip !== 2'd1 || busy !== 1'b1)
            $display("FAIL stall_hold got ref_addr=%0d strip=%0d busy=%b exp 40 1 1", ref_addr, strip, busy);
         else n_pass++;
         @(posedge clk); #1;
      end
      stall = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ref_valid !== 1'b1 || ref_addr !== 6'd40 || bnd_rd !== 1'b1)
         $display("FAIL stall_resume got rv=%b addr=%0d rd=%b exp 1 40 1", ref_valid, ref_addr, bnd_rd);
      else n_pass++;
      wait_done(n0, 400, lat, nbusy, seen);
      n_checks++;
      if (lat !== TOTAL + 6) $display("FAIL stall_latency got=%0d exp=%0d", lat, TOTAL + 6);
      else n_pass++;
`ifdef SW_CTRL_PERF_EN
      n_checks++;
      if (perf_cycles !== 16'(TOTAL + 5)) $display("FAIL perf_stall got=%0d exp=%0d", perf_cycles, TOTAL + 5);
      else n_pass++;
`endif
      n_checks++;
      if (q_exp.size() + r_exp.size() + w_exp.size() + rd_exp.size() + pe_exp.size() != 0)
         $display("FAIL sb_leftover_stall got=%0d exp=0",
                  q_exp.size() + r_exp.size() + w_exp.size() + rd_exp.size() + pe_exp.size());
      else n_pass++;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_start_ignored();
      int n0, lat, nbusy;
      bit seen;
      start_run(n0);
      repeat (100) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(n0, 400, lat, nbusy, seen);
      n_checks++;
      if (lat !== TOTAL + 1) $display("FAIL ignored_start_latency got=%0d exp=%0d", lat, TOTAL + 1);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL ignored_start_restart got busy=%b exp 0", busy);
      else n_pass++;
      n_checks++;
      if (q_exp.size() + r_exp.size() + w_exp.size() + rd_exp.size() + pe_exp.size() != 0)
         $display("FAIL sb_leftover_ignored got=%0d exp=0",
                  q_exp.size() + r_exp.size() + w_exp.size() + rd_exp.size() + pe_exp.size());
      else n_pass++;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset_mid_run();
      int n0, lat, nbusy;
      bit seen, any_done;
      start_run(n0);
      repeat (141) @(posedge clk);
      #1 reset = 1'b1;
      flush_sb();
      @(negedge clk);
      n_checks++;
      if ({busy, done, q_load, ref_valid, bnd_wr, bnd_rd} !== 6'b0 || pe_active !== '0)
         $display("FAIL midreset_strobes got=%b pe=%h exp 0",
                  {busy, done, q_load, ref_valid, bnd_wr, bnd_rd}, pe_active);
      else n_pass++;
      n_checks++;
      if ({strip, q_addr, ref_addr, bnd_wr_addr, bnd_rd_addr} !== 26'b0)
         $display("FAIL midreset_addrs got=%h exp=0", {strip, q_addr, ref_addr, bnd_wr_addr, bnd_rd_addr});
      else n_pass++;
      @(posedge clk); #1 reset = 1'b0;
      any_done = 1'b0;
      repeat (200) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) any_done = 1'b1;
      end
      n_checks++;
      if (any_done) $display("FAIL midreset_no_done got=activity exp=idle");
      else n_pass++;
      start_run(n0);
      wait_done(n0, 400, lat, nbusy, seen);
      n_checks++;
      if (lat !== TOTAL + 1 || nbusy !== TOTAL)
         $display("FAIL rerun_after_reset got lat=%0d busy=%0d exp %0d %0d", lat, nbusy, TOTAL + 1, TOTAL);
      else n_pass++;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_single_strip();
      int n0, nbusy, rel;
      bit seen, bnd_seen;
      @(posedge clk); #1 start48 = 1'b1;
      @(posedge clk); #1 start48 = 1'b0;
      n0 = cyc;
      nbusy = 0; seen = 1'b0; bnd_seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         rel = cyc - n0;
         if (busy48 === 1'b1) nbusy++;
         if (bnd_wr48 === 1'b1 || bnd_rd48 === 1'b1 || strip48 !== 1'b0) bnd_seen = 1'b1;
         if (rel == 48) begin
            n_checks++;
            if (pe_active48 !== 48'h1) $display("FAIL pe48_t0 got=%h exp=000000000001", pe_active48);
            else n_pass++;
         end
         if (rel == 48 + 47) begin
            n_checks++;
            if (pe_active48 !== {48{1'b1}}) $display("FAIL pe48_t47 got=%h exp=ffffffffffff", pe_active48);
            else n_pass++;
         end
         if (done48 === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (!seen || nbusy !== 159) $display("FAIL single_strip_busy got seen=%b busy=%0d exp 1 159", seen, nbusy);
      else n_pass++;
      n_checks++;
      if (bnd_seen) $display("FAIL single_strip_bnd got=asserted exp=never");
      else n_pass++;
`ifdef SW_CTRL_PERF_EN
      n_checks++;
      if (perf_cycles48 !== 16'd159) $display("FAIL perf48 got=%0d exp=159", perf_cycles48);
      else n_pass++;
`endif
      repeat (2) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_start_ignored();
      test_reset_mid_run();
      test_single_strip();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
